// File: rtl/ddmtd_lock_monitor.sv
// Receive-side DDMTD debug-word monitor: resync, signed error rebuild, EMA, lock FSM, stale timeout.
// Optional min/max tracking is built when DDMTD_MON_MINMAX_EN is defined.
module ddmtd_lock_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_THR    = 4,
  parameter int LOCK_CNT    = 16,
  parameter int MISS_CNT    = 4,
  parameter int AVG_SH      = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dbg_in,
  input  logic        clr_stats,
  output logic        sample_stb,
  output logic [6:0]  err_last,
  output logic [6:0]  err_avg,
  output logic [15:0] sample_cnt,
  output logic [1:0]  state,
  output logic        locked,
  output logic        lost_pulse,
  output logic        stale,
  output logic [6:0]  err_min,
  output logic [6:0]  err_max
);

  localparam int          AW     = 7 + AVG_SH;
  localparam logic [6:0]  THR7   = 7'(LOCK_THR);
  localparam logic [7:0]  LCNT8  = 8'(LOCK_CNT);
  localparam logic [7:0]  MCNT8  = 8'(MISS_CNT);
  localparam logic [19:0] TMO    = 20'(TIMEOUT_CYC);
  localparam bit          TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {ST_UNL = 2'b00, ST_ACQ = 2'b01, ST_LCK = 2'b10} st_e;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic                        bit0_dly_q;
  logic                        det_q;
  logic [7:1]                  dat_q;

  // Edge detection is registered, so a sample lands one edge after the synced rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      bit0_dly_q <= 1'b0;
      det_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], dbg_in};
      bit0_dly_q <= sync_q[SYNC_STAGES-1][0];
      det_q      <= sync_q[SYNC_STAGES-1][0] & ~bit0_dly_q;
      if (sync_q[SYNC_STAGES-1][0] & ~bit0_dly_q)
        dat_q <= sync_q[SYNC_STAGES-1][7:1];
    end
  end

  logic                 smp;
  logic signed [6:0]    err_s;
  logic [6:0]           err_abs;
  logic                 inwin;
  logic signed [AW-1:0] acc_q, acc_d, acc_sh, err_ext;

  assign smp     = det_q;
  assign err_s   = {dat_q[1], dat_q[7:2]};
  assign err_abs = err_s[6] ? (~err_s + 7'd1) : err_s;
  // -64 has no 7-bit magnitude, so it is forced out of window.
  assign inwin   = (err_s != 7'h40) && (err_abs <= THR7);
  assign err_ext = {{AVG_SH{err_s[6]}}, err_s};
  assign acc_sh  = acc_q >>> AVG_SH;
  assign acc_d   = acc_q + err_ext - acc_sh;

  logic        sample_stb_q;
  logic [6:0]  err_last_q;
  logic [15:0] sample_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_stb_q <= 1'b0;
      err_last_q   <= '0;
      acc_q        <= '0;
      sample_cnt_q <= '0;
    end else begin
      sample_stb_q <= smp;
      if (smp) begin
        err_last_q <= err_s;
        acc_q      <= acc_d;
      end
      if (clr_stats)
        sample_cnt_q <= smp ? 16'd1 : 16'd0;
      else if (smp && (sample_cnt_q != 16'hFFFF))
        sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end

  logic [19:0] idle_q, idle_d;
  logic        tmo;

  always_comb begin
    idle_d = idle_q;
    tmo    = 1'b0;
    if (smp)
      idle_d = '0;
    else if (TMO_EN && (idle_q != TMO)) begin
      idle_d = idle_q + 20'd1;
      tmo    = (idle_d == TMO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end

  st_e        state_q;
  logic [7:0] hit_q, miss_q;
  logic       lost_q, stale_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNL;
      hit_q   <= '0;
      miss_q  <= '0;
      lost_q  <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      if (smp) begin
        stale_q <= 1'b0;
        case (state_q)
          ST_UNL: begin
            if (inwin) begin
              if (LCNT8 == 8'd1) begin
                state_q <= ST_LCK;
                hit_q   <= '0;
                miss_q  <= '0;
              end else begin
                state_q <= ST_ACQ;
                hit_q   <= 8'd1;
              end
            end else begin
              hit_q <= '0;
            end
          end
          ST_ACQ: begin
            if (!inwin) begin
              state_q <= ST_UNL;
              hit_q   <= '0;
            end else if ((hit_q + 8'd1) == LCNT8) begin
              state_q <= ST_LCK;
              hit_q   <= '0;
              miss_q  <= '0;
            end else begin
              hit_q <= hit_q + 8'd1;
            end
          end
          ST_LCK: begin
            if (inwin)
              miss_q <= '0;
            else if ((miss_q + 8'd1) == MCNT8) begin
              state_q <= ST_UNL;
              miss_q  <= '0;
              lost_q  <= 1'b1;
            end else
              miss_q <= miss_q + 8'd1;
          end
          default: state_q <= ST_UNL;
        endcase
      end else if (tmo) begin
        stale_q <= 1'b1;
        state_q <= ST_UNL;
        hit_q   <= '0;
        miss_q  <= '0;
        lost_q  <= (state_q == ST_LCK);
      end
    end
  end

  assign sample_stb = sample_stb_q;
  assign err_last   = err_last_q;
  assign err_avg    = acc_sh[6:0];
  assign sample_cnt = sample_cnt_q;
  assign state      = state_q;
  assign locked     = (state_q == ST_LCK);
  assign lost_pulse = lost_q;
  assign stale      = stale_q;

`ifdef DDMTD_MON_MINMAX_EN
  logic signed [6:0] min_q, max_q;
  logic              seen_q;

  // Sentinels +63/-64 make the first sample load both extremes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q  <= 7'sd63;
      max_q  <= -7'sd64;
      seen_q <= 1'b0;
    end else if (clr_stats) begin
      min_q  <= smp ? err_s : 7'sd63;
      max_q  <= smp ? err_s : -7'sd64;
      seen_q <= smp;
    end else if (smp) begin
      if (err_s < min_q) min_q <= err_s;
      if (err_s > max_q) max_q <= err_s;
      seen_q <= 1'b1;
    end
  end

  assign err_min = seen_q ? min_q : '0;
  assign err_max = seen_q ? max_q : '0;
`else
  assign err_min = '0;
  assign err_max = '0;
`endif

endmodule

// File: tb/tb_ddmtd_lock_monitor.sv
// Bench for ddmtd_lock_monitor: table of samples with FSM expectations, scoreboard for per-sample outputs.
module tb_ddmtd_lock_monitor;
  localparam int SH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dbg_in;
  logic        clr_stats;
  logic        sample_stb;
  logic [6:0]  err_last, err_avg, err_min, err_max;
  logic [15:0] sample_cnt;
  logic [1:0]  state;
  logic        locked, lost_pulse, stale;

  always #5 clk = ~clk;

  ddmtd_lock_monitor #(
    .SYNC_STAGES(2), .LOCK_THR(4), .LOCK_CNT(16), .MISS_CNT(4),
    .AVG_SH(SH), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .dbg_in(dbg_in), .clr_stats(clr_stats),
    .sample_stb(sample_stb), .err_last(err_last), .err_avg(err_avg),
    .sample_cnt(sample_cnt), .state(state), .locked(locked),
    .lost_pulse(lost_pulse), .stale(stale), .err_min(err_min), .err_max(err_max)
  );

  typedef struct {int err; bit clr; logic [1:0] st; bit lost;} vec_t;
  typedef struct {int err; int avg; int cnt; logic [1:0] st; bit lost; int mn; int mx;} exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   acc = 0, cnt = 0, mn = 63, mx = -64;
  bit   seen = 0;
  int   npush = 0, npulse = 0;
  int   cyc = 0, last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input int e, input bit c, input logic [1:0] s, input bit l, input int n);
    for (int k = 0; k < n; k++) vt.push_back('{err:e, clr:c, st:s, lost:l});
  endfunction

  function automatic void model(input vec_t v);
    int emn, emx;
    acc = acc + v.err - (acc >>> SH);
    if (v.clr) cnt = 1;
    else if (cnt != 65535) cnt = cnt + 1;
    if (v.clr || !seen) begin mn = v.err; mx = v.err; end
    else begin
      if (v.err < mn) mn = v.err;
      if (v.err > mx) mx = v.err;
    end
    seen = 1;
`ifdef DDMTD_MON_MINMAX_EN
    emn = mn; emx = mx;
`else
    emn = 0; emx = 0;
`endif
    sb.push_back('{err:v.err, avg:(acc >>> SH), cnt:cnt, st:v.st, lost:v.lost, mn:emn, mx:emx});
    npush++;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && sample_stb) begin
      npulse++;
      last_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        e = sb.pop_front();
        chk("err_last", $signed(err_last), e.err);
        chk("err_avg", $signed(err_avg), e.avg);
        chk("sample_cnt", int'(sample_cnt), e.cnt);
        chk("state", int'(state), int'(e.st));
        chk("locked", int'(locked), int'(e.st == 2'b10));
        chk("lost_pulse", int'(lost_pulse), int'(e.lost));
        chk("stale_after_sample", int'(stale), 0);
        chk("err_min", $signed(err_min), e.mn);
        chk("err_max", $signed(err_max), e.mx);
      end
    end
  end

  task automatic send(input vec_t v, input bit lat, input int hold);
    logic [6:0] eb;
    eb = 7'(v.err);
    @(negedge clk);
    model(v);
    dbg_in = {eb[5:0], eb[6], 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      if (lat) begin #1; chk("latency_stb_low", int'(sample_stb), 0); end
    end
    @(negedge clk); clr_stats = v.clr;
    @(posedge clk);
    @(negedge clk); clr_stats = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      if (lat && k == 0) begin #1; chk("stb_one_shot", int'(sample_stb), 0); end
    end
    @(negedge clk); dbg_in[0] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int seg_b, seg_c, seg_d, seg_f, tgt;
    add(5, 0, 2'b00, 0, 1);
    add(2, 0, 2'b01, 0, 15); add(2, 0, 2'b10, 0, 1); add(2, 0, 2'b10, 0, 20);
    seg_b = vt.size();
    add(-20, 0, 2'b10, 0, 3); add(0, 0, 2'b10, 0, 1);
    add(-20, 0, 2'b10, 0, 3); add(-20, 0, 2'b00, 1, 1);
    seg_c = vt.size();
    add(2, 0, 2'b01, 0, 10); add(-64, 0, 2'b00, 0, 1);
    add(2, 0, 2'b01, 0, 15); add(2, 0, 2'b10, 0, 1);
    seg_d = vt.size();
    add(2, 0, 2'b01, 0, 1);
    add(7, 0, 2'b00, 0, 1); add(-3, 0, 2'b01, 0, 1); add(12, 0, 2'b00, 0, 1);
    seg_f = vt.size();
    add(-1, 1, 2'b01, 0, 1);

    rst = 1'b1; dbg_in = '0; clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_stb", int'(sample_stb), 0);
    chk("rst_err_last", int'(err_last), 0);
    chk("rst_err_avg", int'(err_avg), 0);
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_lost", int'(lost_pulse), 0);
    chk("rst_stale", int'(stale), 0);
    chk("rst_err_min", int'(err_min), 0);
    chk("rst_err_max", int'(err_max), 0);
    @(negedge clk); rst = 1'b0;

    send(vt[0], 1, 10);
    for (int i = 1; i < seg_b; i++) send(vt[i], 0, 0);
    chk("avg_converged", $signed(err_avg), 2);
    for (int i = seg_b; i < seg_d; i++) send(vt[i], 0, 0);

    tgt = last_cyc + 99;
    for (int k = 0; k < 300 && cyc < tgt; k++) begin @(posedge clk); #1; end
    chk("timeout_wait_bound", cyc, tgt);
    chk("pre_timeout_stale", int'(stale), 0);
    chk("pre_timeout_state", int'(state), 2);
    @(posedge clk); #1;
    chk("timeout_stale", int'(stale), 1);
    chk("timeout_lost", int'(lost_pulse), 1);
    chk("timeout_state", int'(state), 0);
    chk("timeout_locked", int'(locked), 0);
    @(posedge clk); #1;
    chk("timeout_lost_one_cycle", int'(lost_pulse), 0);
    chk("timeout_stale_held", int'(stale), 1);

    send(vt[seg_d], 0, 0);

    @(negedge clk); clr_stats = 1'b1;
    cnt = 0; mn = 63; mx = -64; seen = 0;
    @(posedge clk); #1;
    chk("clr_sample_cnt", int'(sample_cnt), 0);
    chk("clr_err_min", int'(err_min), 0);
    chk("clr_err_max", int'(err_max), 0);
    @(negedge clk); clr_stats = 1'b0;

    for (int i = seg_d + 1; i < seg_f; i++) send(vt[i], 0, 0);
`ifdef DDMTD_MON_MINMAX_EN
    chk("pre_clr_min", $signed(err_min), -3);
    chk("pre_clr_max", $signed(err_max), 12);
`else
    chk("pre_clr_min_tied", $signed(err_min), 0);
    chk("pre_clr_max_tied", $signed(err_max), 0);
`endif
    send(vt[seg_f], 0, 0);

    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_sample_cnt", int'(sample_cnt), 0);
    chk("midrst_err_last", int'(err_last), 0);
    chk("midrst_err_avg", int'(err_avg), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    chk("scoreboard_drained", sb.size(), 0);
    chk("pulse_count", npulse, npush);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
